// File: rtl/gap_pool_unit_pkg.sv
// gap_pkg: shared FSM state type and sizing/masking helpers for the global-average-pooling engine.
package gap_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
  function automatic int acc_w(input int data_w, input int pix_log2);
    return data_w + pix_log2;
  endfunction
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  function automatic logic lane_mask(input int k, input int n);
    return k < n;
  endfunction
endpackage

// File: rtl/gap_pool_unit_lane_sum.sv
// gap_lane_sum: combinational sum of the lanes below the given lane count in one beat.
module gap_lane_sum import gap_pkg::*; #(
  parameter int DATA_W = 10,
  parameter int LANES  = 9
) (
  input  logic [LANES*DATA_W-1:0]           i_data,
  input  logic [$clog2(LANES+1)-1:0]        i_lane_cnt,
  output logic [DATA_W+$clog2(LANES+1)-1:0] o_sum
);
  localparam int SUM_W = DATA_W + $clog2(LANES + 1);
  always_comb begin
    o_sum = '0;
    for (int k = 0; k < LANES; k++)
      o_sum = o_sum + (lane_mask(k, int'(i_lane_cnt)) ? SUM_W'(i_data[k*DATA_W +: DATA_W]) : SUM_W'(0));
  end
endmodule

// File: rtl/gap_pool_unit.sv
// gap_pool_unit: lane-parallel global-average-pooling engine, NUM_CH channels of 2^PIX_LOG2 pixels per start.
// Optional round-half-up averaging when GAP_ROUND_EN is defined; truncating shift otherwise.
module gap_pool_unit import gap_pkg::*; #(
  parameter int DATA_W   = 10,
  parameter int LANES    = 9,
  parameter int PIX_LOG2 = 12,
  parameter int NUM_CH   = 2
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [$clog2(LANES+1)-1:0]  i_lane_cnt,
  input  logic [LANES*DATA_W-1:0]     i_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [DATA_W-1:0]           o_data,
  output logic [cnt_w(NUM_CH)-1:0]    o_ch,
  output logic                        o_done,
  output logic                        o_busy,
  output logic                        o_err
);
  localparam int LC_W  = $clog2(LANES + 1);
  localparam int SUM_W = DATA_W + LC_W;
  localparam int ACC_W = acc_w(DATA_W, PIX_LOG2);
  localparam int PC_W  = PIX_LOG2 + 1;
  localparam int CH_W  = cnt_w(NUM_CH);
  localparam logic [PC_W-1:0] PIX_N = PC_W'(1) << PIX_LOG2;
`ifdef GAP_ROUND_EN
  localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (PIX_LOG2 - 1);
`else
  localparam logic [ACC_W-1:0] RND = '0;
`endif
  state_t                r_state, w_next;
  logic [ACC_W-1:0]      r_acc, w_acc_nxt;
  logic [PC_W-1:0]       r_pix, w_rem, w_pix_nxt;
  logic [CH_W-1:0]       r_ch;
  logic [DATA_W-1:0]     r_data, w_avg;
  logic                  r_valid, r_done, r_err;
  logic                  w_legal, w_over, w_fire, w_last, w_hs, w_final_ch;
  logic [LC_W-1:0]       w_req, w_take;
  logic [LANES*DATA_W-1:0] w_masked;
  logic [SUM_W-1:0]      w_sum;
  assign w_legal    = (i_lane_cnt != '0) && (int'(i_lane_cnt) <= LANES);
  assign w_req      = w_legal ? i_lane_cnt : '0;
  assign w_rem      = PIX_N - r_pix;
  assign w_over     = PC_W'(w_req) > w_rem;
  // an overshooting beat is clipped to the pixels still owed to this channel
  assign w_take     = w_over ? w_rem[LC_W-1:0] : w_req;
  assign w_pix_nxt  = r_pix + PC_W'(w_take);
  assign w_fire     = (r_state == ACCUM) && i_valid;
  assign w_last     = w_pix_nxt == PIX_N;
  assign w_hs       = (r_state == OUT) && r_valid && i_ready;
  assign w_final_ch = r_ch == CH_W'(NUM_CH - 1);
  for (genvar k = 0; k < LANES; k++) begin : g_mask
    assign w_masked[k*DATA_W +: DATA_W] = lane_mask(k, int'(w_take)) ? i_data[k*DATA_W +: DATA_W] : '0;
  end
  gap_lane_sum #(.DATA_W(DATA_W), .LANES(LANES)) u_sum (
    .i_data     (w_masked),
    .i_lane_cnt (w_take),
    .o_sum      (w_sum)
  );
  assign w_acc_nxt = r_acc + ACC_W'(w_sum);
  assign w_avg     = DATA_W'((w_acc_nxt + RND) >> PIX_LOG2);
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && i_start) w_next = ACCUM;
    if (w_fire && w_last)           w_next = OUT;
    if (w_hs)                       w_next = w_final_ch ? IDLE : ACCUM;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc   <= '0;
      r_pix   <= '0;
      r_ch    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE && i_start) begin
        r_acc <= '0;
        r_pix <= '0;
        r_ch  <= '0;
        r_err <= 1'b0;
      end
      if (w_fire) begin
        r_acc <= w_acc_nxt;
        r_pix <= w_pix_nxt;
        if (w_over || !w_legal) r_err <= 1'b1;
        if (w_last) begin
          r_valid <= 1'b1;
          r_data  <= w_avg;
        end
      end
      if (w_hs) begin
        r_valid <= 1'b0;
        r_acc   <= '0;
        r_pix   <= '0;
        r_done  <= w_final_ch;
        r_ch    <= w_final_ch ? '0 : r_ch + 1'b1;
      end
    end
  end
  assign o_ready = r_state == ACCUM;
  assign o_busy  = r_state != IDLE;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ch    = r_ch;
  assign o_done  = r_done;
  assign o_err   = r_err;
endmodule

// File: tb/tb_gap_pool_unit.sv
// tb_gap_pool_unit: randomized self-checking bench for gap_pool_unit against a pixel-sum reference model.
module tb_gap_pool_unit;
  logic        clk = 1'b0;
  logic        rst, start, vld, rdy_out, rdy_in, ov, done, busy, err;
  logic [3:0]  lc;
  logic [89:0] data;
  logic [9:0]  od;
  logic [0:0]  och;
  int total = 0;
  int bad   = 0;
  always #5 clk = ~clk;
  gap_pool_unit dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_valid(vld), .o_ready(rdy_out),
    .i_lane_cnt(lc), .i_data(data), .o_valid(ov), .i_ready(rdy_in), .o_data(od),
    .o_ch(och), .o_done(done), .o_busy(busy), .o_err(err)
  );
  function automatic int exp_avg(input longint s);
`ifdef GAP_ROUND_EN
    return int'((s + 2048) >> 12);
`else
    return int'(s >> 12);
`endif
  endfunction
  task automatic do_reset;
    rst = 1; start = 0; vld = 0; rdy_in = 0; lc = 0; data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask
  task automatic pulse_start;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  // kind 0: constant val; 1: random pixels; 2: pixel index < val gives 1, else 0
  task automatic feed(input int kind, input int val, input bit rnd, input bit ovs, input int max_beats,
                      output longint sum, output bit ovr);
    int rem, beats, cnt, take, n, idx, p;
    logic [89:0] d;
    rem = 4096; beats = 0; sum = 0; ovr = 0;
    while (rem > 0 && beats < max_beats) begin
      if (rnd) cnt = ($urandom_range(0, 24) == 0) ? (($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(10, 15)))
                                                  : int'($urandom_range(1, 9));
      else     cnt = ovs ? 9 : (rem < 9 ? rem : 9);
      for (int k = 0; k < 9; k++) begin
        idx = 4096 - rem + k;
        p = (kind == 0) ? val : (kind == 1) ? int'($urandom_range(0, 1023)) : (idx < val ? 1 : 0);
        if (k >= cnt) p = int'($urandom_range(0, 1023));
        d[k*10 +: 10] = p[9:0];
      end
      take = (cnt >= 1 && cnt <= 9) ? (cnt < rem ? cnt : rem) : 0;
      if (cnt < 1 || cnt > 9 || cnt > rem) ovr = 1;
      for (int k = 0; k < take; k++) sum += longint'(d[k*10 +: 10]);
      if (rnd && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        vld = 0;
      end
      @(negedge clk);
      vld = 1; lc = cnt[3:0]; data = d;
      n = 0;
      while (!rdy_out && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!rdy_out) break;
      @(posedge clk);
      rem -= take;
      beats++;
    end
    @(negedge clk);
    vld = 0;
  endtask
  task automatic get_out(input int hold, output logic [9:0] d, output logic c, output logic got,
                         output logic dn, output logic va);
    int n;
    n = 0;
    @(negedge clk);
    while (!ov && n < 20) begin
      @(negedge clk);
      n++;
    end
    got = ov; d = od; c = och[0];
    repeat (hold) @(negedge clk);
    rdy_in = 1;
    @(posedge clk);
    @(negedge clk);
    dn = done; va = ov;
    rdy_in = 0;
  endtask
  task automatic test_reset;
    do_reset();
    total++;
    if ({ov, rdy_out, busy, done, err, od, och} !== 16'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {ov, rdy_out, busy, done, err, od, och});
    end
  endtask
  task automatic test_const;
    int v[4] = '{8, 200, 1023, 100};
    longint s; bit o; logic [9:0] d; logic c, g, dn, va;
    logic [13:0] got, want;
    for (int r = 0; r < 2; r++) begin
      pulse_start();
      total++;
      if ({busy, err} !== 2'b10) begin
        bad++;
        $display("FAIL const_start got=%b want=10", {busy, err});
      end
      for (int ch = 0; ch < 2; ch++) begin
        feed(0, v[r*2+ch], 0, 0, 1000, s, o);
        get_out(0, d, c, g, dn, va);
        got = {g, d, c, dn, va};
        want = {1'b1, 10'(exp_avg(s)), ch[0], ch == 1, 1'b0};
        total++;
        if (got !== want || exp_avg(s) != v[r*2+ch]) begin
          bad++;
          $display("FAIL const_out r%0d ch%0d got=%h want=%h", r, ch, got, want);
        end
      end
      @(negedge clk);
      total++;
      if ({done, busy, err} !== 3'b000) begin
        bad++;
        $display("FAIL const_idle got=%b want=000", {done, busy, err});
      end
    end
  endtask
  task automatic test_round;
    longint s0, s1; bit o; logic [9:0] d0, d1; logic c, g, dn, va;
    pulse_start();
    feed(2, 2048, 0, 0, 1000, s0, o);
    get_out(0, d0, c, g, dn, va);
    feed(2, 2047, 0, 0, 1000, s1, o);
    get_out(0, d1, c, g, dn, va);
    total++;
`ifdef GAP_ROUND_EN
    if (d0 !== 10'd1 || 10'(exp_avg(s0)) !== 10'd1) begin
      bad++;
      $display("FAIL round_2048 got=%0d want=1", d0);
    end
`else
    if (d0 !== 10'd0 || 10'(exp_avg(s0)) !== 10'd0) begin
      bad++;
      $display("FAIL round_2048 got=%0d want=0", d0);
    end
`endif
    total++;
    if (d1 !== 10'd0 || {g, dn} !== 2'b11) begin
      bad++;
      $display("FAIL round_2047 got=%0d/%b want=0/11", d1, {g, dn});
    end
  endtask
  task automatic test_backpressure;
    longint s; bit o; logic [9:0] d; logic c, g, dn, va;
    int n;
    pulse_start();
    feed(0, 8, 0, 0, 1000, s, o);
    n = 0;
    while (!ov && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vld = 1; lc = 4'd9; data = {9{10'd555}}; start = (i == 2);
      total++;
      if ({ov, rdy_out, busy, od, och} !== {3'b101, 10'd8, 1'b0}) begin
        bad++;
        $display("FAIL hold_cycle%0d got=%h want=%h", i, {ov, rdy_out, busy, od, och}, {3'b101, 10'd8, 1'b0});
      end
    end
    start = 0; vld = 0;
    get_out(0, d, c, g, dn, va);
    total++;
    if ({g, d, c, dn, va} !== {1'b1, 10'd8, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL bp_ch0 got=%h want=%h", {g, d, c, dn, va}, {1'b1, 10'd8, 3'b000});
    end
    feed(0, 100, 0, 0, 1000, s, o);
    get_out(0, d, c, g, dn, va);
    total++;
    if ({g, d, c, dn, va} !== {1'b1, 10'd100, 1'b1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL bp_ch1 got=%h want=%h", {g, d, c, dn, va}, {1'b1, 10'd100, 3'b110});
    end
  endtask
  task automatic test_overshoot;
    longint s; bit o; logic [9:0] d; logic c, g, dn, va;
    pulse_start();
    feed(0, 8, 0, 1, 1000, s, o);
    get_out(0, d, c, g, dn, va);
    total++;
    if ({g, d, err, o} !== {1'b1, 10'd8, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL overshoot got=%h want=%h", {g, d, err, o}, {1'b1, 10'd8, 2'b11});
    end
    feed(0, 8, 0, 0, 1000, s, o);
    get_out(0, d, c, g, dn, va);
    @(negedge clk);
    total++;
    if ({dn, err, busy} !== 3'b110) begin
      bad++;
      $display("FAIL err_sticky got=%b want=110", {dn, err, busy});
    end
    pulse_start();
    total++;
    if ({err, busy} !== 2'b01) begin
      bad++;
      $display("FAIL err_clear got=%b want=01", {err, busy});
    end
  endtask
  task automatic test_reset_mid;
    longint s; bit o; logic [9:0] d; logic c, g, dn, va;
    logic seen;
    pulse_start();
    feed(0, 8, 0, 0, 200, s, o);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen |= ov | busy | rdy_out | done;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort got=%b want=0", seen);
    end
    pulse_start();
    for (int ch = 0; ch < 2; ch++) begin
      feed(0, 8, 0, 0, 1000, s, o);
      get_out(0, d, c, g, dn, va);
      total++;
      if ({g, d, c, dn} !== {1'b1, 10'd8, ch[0], ch == 1}) begin
        bad++;
        $display("FAIL reset_rerun ch%0d got=%h want=%h", ch, {g, d, c, dn}, {1'b1, 10'd8, ch[0], ch == 1});
      end
    end
  endtask
  task automatic test_random;
    longint s; bit o, run_err; logic [9:0] d; logic c, g, dn, va;
    for (int r = 0; r < 3; r++) begin
      pulse_start();
      run_err = 0;
      for (int ch = 0; ch < 2; ch++) begin
        feed(1, 0, 1, 0, 3000, s, o);
        run_err |= o;
        get_out(int'($urandom_range(0, 4)), d, c, g, dn, va);
        total++;
        if ({g, d, c, dn, va, err} !== {1'b1, 10'(exp_avg(s)), ch[0], ch == 1, 1'b0, run_err}) begin
          bad++;
          $display("FAIL random r%0d ch%0d got=%h want=%h", r, ch, {g, d, c, dn, va, err},
                   {1'b1, 10'(exp_avg(s)), ch[0], ch == 1, 1'b0, run_err});
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_const();
    test_round();
    test_backpressure();
    test_overshoot();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
